// File: rtl/demux_4ch_buf_pkg.sv
// -----------------------------------------------------------------------------
// demux_4ch_buf_pkg
//   Shared constants and helpers for the 1-to-4 buffered stream demultiplexer.
//   NUM_CH : number of output channels
//   SEL_W  : width of the channel select
//   clog2  : ceiling log2, used to size FIFO pointers and counts
// -----------------------------------------------------------------------------
package demux_4ch_buf_pkg;

    localparam int NUM_CH = 4;
    localparam int SEL_W  = 2;

    // Ceiling log2 for n >= 1. Evaluated at elaboration time only.
    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = n - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/demux_4ch_buf_if.sv
// -----------------------------------------------------------------------------
// demux_4ch_buf_if
//   Bundles the producer handshake and the four sink lanes of demux_4ch_buf.
//   in_data/in_sel/in_valid/in_ready : single producer side
//   out_data/out_valid/out_ready     : four consumer lanes, lane k at
//                                      out_data[k*WIDTH +: WIDTH]
//   chan_full                        : per-lane FIFO full status
//   Modport slave is the demultiplexer, master is the producer/consumer side.
// -----------------------------------------------------------------------------
interface demux_4ch_buf_if
    import demux_4ch_buf_pkg::*;
#(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0]        in_data;
    logic [SEL_W-1:0]        in_sel;
    logic                    in_valid;
    logic                    in_ready;
    logic [NUM_CH*WIDTH-1:0] out_data;
    logic [NUM_CH-1:0]       out_valid;
    logic [NUM_CH-1:0]       out_ready;
    logic [NUM_CH-1:0]       chan_full;

    modport slave (
        input  in_data,
        input  in_sel,
        input  in_valid,
        output in_ready,
        output out_data,
        output out_valid,
        input  out_ready,
        output chan_full
    );

    modport master (
        output in_data,
        output in_sel,
        output in_valid,
        input  in_ready,
        input  out_data,
        input  out_valid,
        output out_ready,
        input  chan_full
    );

endinterface

// File: rtl/demux_4ch_buf_chan_fifo.sv
// -----------------------------------------------------------------------------
// demux_chan_fifo
//   Small synchronous FIFO used as one channel buffer of demux_4ch_buf.
//   clk, rst : clock, asynchronous active-high reset (clears pointers,
//              count and storage so rdata is never X)
//   push     : write wdata this cycle (ignored when full)
//   wdata    : word to write
//   pop      : advance read pointer this cycle (ignored when empty)
//   rdata    : head word (combinational read of the registered storage)
//   empty    : no words held
//   full     : DEPTH words held
// -----------------------------------------------------------------------------
module demux_chan_fifo
    import demux_4ch_buf_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             empty,
    output logic             full
);

    localparam int PTR_W = clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic do_push;
    logic do_pop;

    assign empty = (count_q == '0);
    assign full  = (count_q == CNT_W'(DEPTH));
    assign rdata = mem_q[rd_ptr_q];

    // Guard locally as well so the FIFO is safe regardless of the caller.
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = wdata;
            // DEPTH is a power of two, so natural overflow is the modulo wrap.
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/demux_4ch_buf.sv
// -----------------------------------------------------------------------------
// demux_4ch_buf
//   1-to-4 stream demultiplexer with a small FIFO per output channel so the
//   four sinks drain independently.
//   clk : rising-edge clock
//   rst : asynchronous active-high reset; drops all buffered words at once
//   bus : demux_4ch_buf_if.slave
//         in_data/in_sel/in_valid -> in_ready   producer handshake
//         out_data/out_valid <- out_ready        four sink lanes
//         chan_full                              per-lane full flag
//   WIDTH must match the WIDTH of the connected interface instance.
// -----------------------------------------------------------------------------
module demux_4ch_buf
    import demux_4ch_buf_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    demux_4ch_buf_if.slave   bus
);

    logic [NUM_CH-1:0] push_w;
    logic [NUM_CH-1:0] empty_w;
    logic [NUM_CH-1:0] full_w;
    logic              in_ready_w;

    // No pass-through: readiness depends only on registered fullness, so a
    // full channel stays not-ready even when it is popping this cycle.
    assign in_ready_w    = ~full_w[bus.in_sel];
    assign bus.in_ready  = in_ready_w;
    assign bus.out_valid = ~empty_w;
    assign bus.chan_full = full_w;

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_chan
            assign push_w[gi] = bus.in_valid & in_ready_w &
                                (bus.in_sel == SEL_W'(gi));

            demux_chan_fifo #(
                .WIDTH (WIDTH),
                .DEPTH (DEPTH)
            ) u_fifo (
                .clk   (clk),
                .rst   (rst),
                .push  (push_w[gi]),
                .wdata (bus.in_data),
                .pop   (bus.out_ready[gi]),
                .rdata (bus.out_data[gi*WIDTH +: WIDTH]),
                .empty (empty_w[gi]),
                .full  (full_w[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_demux_4ch_buf.sv
// -----------------------------------------------------------------------------
// tb_demux_4ch_buf
//   Directed bench for demux_4ch_buf. A per-channel scoreboard queue holds the
//   words the bench expects to see; words are pushed when the bench's own
//   capacity model says the producer is accepted and popped when a consumer
//   takes the head.
// -----------------------------------------------------------------------------
module tb_demux_4ch_buf;
    import demux_4ch_buf_pkg::*;

    localparam int WIDTH = 8;
    localparam int DEPTH = 2;

    logic clk;
    logic rst;

    demux_4ch_buf_if #(.WIDTH(WIDTH)) bus ();

    demux_4ch_buf #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp;
    int n_err;
    logic [WIDTH-1:0] exp_q [NUM_CH][$];
    logic last_acc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_model();
        for (int k = 0; k < NUM_CH; k++) exp_q[k].delete();
    endtask

    // Called just after a negedge with inputs already driven. Compares all
    // outputs against the model, advances the model for this edge, then moves
    // to the next negedge.
    task automatic step();
        logic acc;
        int   s;
        #1;
        for (int k = 0; k < NUM_CH; k++) begin
            chk($sformatf("out_valid[%0d]", k), 32'(bus.out_valid[k]), 32'(exp_q[k].size() > 0));
            chk($sformatf("chan_full[%0d]", k), 32'(bus.chan_full[k]), 32'(exp_q[k].size() == DEPTH));
            if (exp_q[k].size() > 0)
                chk($sformatf("out_data[%0d]", k), 32'(bus.out_data[k*WIDTH +: WIDTH]), 32'(exp_q[k][0]));
        end
        s = int'(bus.in_sel);
        chk($sformatf("in_ready sel=%0d", s), 32'(bus.in_ready), 32'(exp_q[s].size() < DEPTH));
        acc = bus.in_valid && (exp_q[s].size() < DEPTH);
        for (int k = 0; k < NUM_CH; k++)
            if (bus.out_ready[k] && exp_q[k].size() > 0) void'(exp_q[k].pop_front());
        if (acc) exp_q[s].push_back(bus.in_data);
        last_acc = acc;
        $display("step t=%0t sel=%0d data=%0h valid=%0b acc=%0b out_ready=%b out_valid=%b",
                 $time, s, bus.in_data, bus.in_valid, acc, bus.out_ready, bus.out_valid);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic [SEL_W-1:0] sel,
                         input logic [WIDTH-1:0] d, input logic [NUM_CH-1:0] ordy);
        bus.in_valid  = v;
        bus.in_sel    = sel;
        bus.in_data   = d;
        bus.out_ready = ordy;
    endtask

    initial begin
        int i;
        int guard;
        n_cmp = 0;
        n_err = 0;
        last_acc = 1'b0;
        clear_model();
        drive(1'b0, 2'd0, 8'h00, 4'b0000);
        rst = 1'b1;

        // Reset state
        #1;
        chk("rst out_valid", 32'(bus.out_valid), 32'h0);
        chk("rst chan_full", 32'(bus.chan_full), 32'h0);
        chk("rst out_data", bus.out_data, 32'h0);
        for (int s = 0; s < NUM_CH; s++) begin
            bus.in_sel = SEL_W'(s);
            #1;
            chk($sformatf("rst in_ready sel=%0d", s), 32'(bus.in_ready), 32'h1);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // 1: async reset with two words buffered in ch1
        drive(1'b1, 2'd1, 8'hC1, 4'b0000); step();
        drive(1'b1, 2'd1, 8'hC2, 4'b0000); step();
        drive(1'b0, 2'd1, 8'h00, 4'b0000);
        #1;
        chk("pre-rst out_valid", 32'(bus.out_valid), 32'h2);
        #1 rst = 1'b1;
        #1;
        chk("mid-rst out_valid", 32'(bus.out_valid), 32'h0);
        chk("mid-rst chan_full", 32'(bus.chan_full), 32'h0);
        clear_model();
        @(negedge clk);
        rst = 1'b0;
        for (int s = 0; s < NUM_CH; s++) begin
            bus.in_sel = SEL_W'(s);
            #1;
            chk($sformatf("post-rst in_ready sel=%0d", s), 32'(bus.in_ready), 32'h1);
        end
        @(negedge clk);

        // 2: route 0xA5 to ch2
        drive(1'b1, 2'd2, 8'hA5, 4'b0000); step();
        drive(1'b0, 2'd0, 8'h00, 4'b0000);
        #1;
        chk("route out_valid", 32'(bus.out_valid), 32'h4);
        chk("route out_data[23:16]", 32'(bus.out_data[23:16]), 32'hA5);
        step();

        // 3: fill ch3, third push refused
        drive(1'b1, 2'd3, 8'h11, 4'b0000); step();
        drive(1'b1, 2'd3, 8'h22, 4'b0000); step();
        drive(1'b0, 2'd3, 8'h00, 4'b0000);
        #1;
        chk("full chan_full[3]", 32'(bus.chan_full[3]), 32'h1);
        chk("full in_ready sel3", 32'(bus.in_ready), 32'h0);
        bus.in_sel = 2'd0;
        #1;
        chk("full in_ready sel0", 32'(bus.in_ready), 32'h1);
        @(negedge clk);
        drive(1'b1, 2'd3, 8'h33, 4'b0000); step();
        chk("third push refused", 32'(last_acc), 32'h0);
        drive(1'b0, 2'd0, 8'h00, 4'b1111);
        repeat (3) step();
        drive(1'b0, 2'd0, 8'h00, 4'b0000); step();

        // 4: simultaneous push+pop on ch0
        drive(1'b1, 2'd0, 8'h01, 4'b0000); step();
        drive(1'b1, 2'd0, 8'h02, 4'b0001); step();
        drive(1'b0, 2'd0, 8'h00, 4'b0000);
        #1;
        chk("simul out_data[0]", 32'(bus.out_data[7:0]), 32'h02);
        chk("simul count=1 full", 32'(bus.chan_full[0]), 32'h0);
        step();
        drive(1'b0, 2'd0, 8'h00, 4'b0001); step();
        drive(1'b0, 2'd0, 8'h00, 4'b0000); step();

        // 5: stream 0x10..0x17 to ch1 with toggling consumer
        i = 0;
        guard = 0;
        while (i < 8 && guard < 64) begin
            drive(1'b1, 2'd1, 8'(8'h10 + i), {2'b00, ~guard[0], 1'b0});
            step();
            if (last_acc) i++;
            guard++;
        end
        chk("stream all accepted", 32'(i), 32'd8);
        drive(1'b0, 2'd0, 8'h00, 4'b0010);
        repeat (3) step();

        // 6: fill all four channels, then drain in parallel
        for (int c = 0; c < NUM_CH; c++)
            for (int j = 0; j < DEPTH; j++) begin
                drive(1'b1, SEL_W'(c), 8'(8'h40 + c * 16 + j), 4'b0000);
                step();
            end
        drive(1'b0, 2'd0, 8'h00, 4'b0000);
        #1;
        chk("all full", 32'(bus.chan_full), 32'hF);
        @(negedge clk);
        drive(1'b0, 2'd0, 8'h00, 4'b1111);
        repeat (2) step();
        drive(1'b0, 2'd0, 8'h00, 4'b0000);
        #1;
        chk("drained out_valid", 32'(bus.out_valid), 32'h0);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
